mod_row_accum: RTL and testbench
================================

# mod_row_accum

Parametrised streaming row accumulator for the prover's modular datapath. Each input element `a` is scaled by `2^w` modulo a prime `MODULUS`, and the products are summed modulo `MODULUS` across one row. Rows end after `ROW_LEN` elements or at an element flagged `in_last`. Input and output use valid/ready handshakes. The scaling is done by iterative modular doubling, so any odd prime and any widths can be used without a dedicated reduction tree.

## Interface
- `WIDTH`, 256: field element / accumulator width in bits.
- `A_W`, 64: input element width; must satisfy `A_W < WIDTH`.
- `SHIFT_W`, 8: width of shift amount `w`.
- `ROW_LEN`, 72: maximum elements per row (≥1).
- `MODULUS`, 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001: prime; must satisfy `2^A_W ≤ MODULUS < 2^WIDTH`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: element offered.
- `in_ready` output 1: block accepts element.
- `in_a` input A_W: element value.
- `in_w` input SHIFT_W: shift amount.
- `in_last` input 1: element closes the row early.
- `out_valid` output 1: row result available.
- `out_ready` input 1: consumer takes result.
- `out_data` output WIDTH: row sum mod `MODULUS`.
- `out_count` output $clog2(ROW_LEN+1): elements in the delivered row.

## Operation
- One clock; reset is asynchronous and active-low. Reset clears all state:
  - FSM goes to IDLE.
  - sum = 0, element count = 0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0.
- FSM states:
  - IDLE: `in_ready`=1. On accept (`in_valid && in_ready`), latch x=`in_a`, sh=`in_w`, last=`in_last || (cnt == ROW_LEN-1)`. Go to SHIFT if `in_w`≠0, else to ACCUM.
  - SHIFT: `in_ready`=0. Each cycle x ← mod_add(x,x) and sh ← sh−1. When sh==1, go to ACCUM.
  - ACCUM: `in_ready`=0. sum ← mod_add(sum,x), cnt ← cnt+1. Go to OUT if last, else to IDLE.
  - OUT: `out_valid`=1; `out_data`=sum and `out_count`=cnt, both stable. On `out_ready`, clear sum and cnt and go to IDLE. Consumer stalls are unbounded.
- mod_add(p,q), for p,q < MODULUS: compute s = p+q at WIDTH+1 bits. Result is s−MODULUS if s ≥ MODULUS, else s. The result is always < MODULUS.
- `in_a` < MODULUS is guaranteed by the parameter constraint, so no pre-reduction is needed.
- `in_last` on the ROW_LEN-th element is the same as a normal row end. `in_last` on the first element gives a one-element row.
- `in_ready` is 0 in OUT, so no element of the next row is accepted until the result is taken.
- `rst_n` asserted mid-row or in OUT discards the partial sum and any pending result with no output.

## Timing
- Accept edge = edge 0. SHIFT occupies edges 1..w, and ACCUM executes at edge w+1.
- `out_valid` (last element) or `in_ready` (otherwise) goes high after edge w+1.
- For w=0, the ACCUM edge is edge 1.
- Element throughput is one element per w+2 cycles.
- For a row of n elements with shifts w_i, the minimum cycles from first accept to `out_valid` = Σ(w_i+2) − 1.
- The OUT→IDLE handoff takes 1 cycle: `in_ready` rises the cycle after the `out_valid && out_ready` edge.
- No combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `mod_pkg`:
  - `MODULUS` default.
  - the `mod_add` function.
  - FSM state enum {IDLE, SHIFT, ACCUM, OUT}.
- Sub-module `mod_adder` (combinational, WIDTH and MODULUS parameters). Two instances: doubler and accumulator.

## Test plan
Directed tests use WIDTH=8, A_W=6, MODULUS=97, ROW_LEN=4.
- Basic row: a={1,2,3,4}, w=0 → out_data=10, out_count=4. `out_valid` rises 7 cycles after the first accept when `in_valid` is held.
- Shift wrap: single element a=1, w=10, in_last=1 → out_data=54, out_count=1. `out_valid` rises after edge 11.
- Accumulate wrap: a={60,60}, w={1,0}, last on the 2nd element → 23+60=83. Then a={60,60,60,0}, w=0 → 180 mod 97 = 83, count=4.
- Backpressure: `out_ready`=0 for 20 cycles with `in_valid` held. Required: `in_ready` stays 0, out_data/out_count stay stable, and the next row starts one cycle after the handshake.
- Reset mid-row: accept a=5 and a=7, assert `rst_n`=0 during SHIFT, release, then send a={1}, last=1 → out_data=1, out_count=1, with no earlier `out_valid`.
- Randomised backpressure cross-check: random a, w ≤ 15, random `in_last`, checked against a reference model of Σ(a·2^w) mod 97.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared definitions for the modular row-accumulator datapath: default
// prime, FSM state encoding and the reference modular addition.
package mod_pkg;

  // Widest operand mod_add handles; narrower datapaths zero-extend into it.
  localparam int MOD_MAX_W = 512;

  localparam logic [255:0] MODULUS_DEFAULT =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACCUM,
    OUT
  } state_e;

  // Operands must already be reduced (p, q < m); one conditional subtract suffices.
  function automatic logic [MOD_MAX_W-1:0] mod_add(input logic [MOD_MAX_W-1:0] p,
                                                   input logic [MOD_MAX_W-1:0] q,
                                                   input logic [MOD_MAX_W-1:0] m);
    logic [MOD_MAX_W:0] s;
    s = {1'b0, p} + {1'b0, q};
    if (s >= {1'b0, m}) begin
      s = s - {1'b0, m};
    end
    return s[MOD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/mod_adder.sv
// Combinational modular adder: sum_o = (a_i + b_i) mod MODULUS for reduced inputs.
module mod_adder
  import mod_pkg::*;
#(
  parameter int               WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(MODULUS_DEFAULT)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = WIDTH'(mod_add(MOD_MAX_W'(a_i), MOD_MAX_W'(b_i), MOD_MAX_W'(MODULUS)));

endmodule

// File: rtl/mod_row_accum.sv
// Streaming row accumulator: sums a*2^w mod MODULUS over rows of up to ROW_LEN
// elements, scaling each element by repeated modular doubling.
module mod_row_accum
  import mod_pkg::*;
#(
  parameter int               WIDTH   = 256,
  parameter int               A_W     = 64,
  parameter int               SHIFT_W = 8,
  parameter int               ROW_LEN = 72,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(MODULUS_DEFAULT),
  localparam int              CNT_W   = $clog2(ROW_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [SHIFT_W-1:0] in_w,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [SHIFT_W-1:0] sh_q, sh_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   dbl_sum;
  logic [WIDTH-1:0]   acc_sum;

  mod_adder #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_doubler (
    .a_i  (x_q),
    .b_i  (x_q),
    .sum_o(dbl_sum)
  );

  mod_adder #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_accum (
    .a_i  (sum_q),
    .b_i  (x_q),
    .sum_o(acc_sum)
  );

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = sum_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    sh_d    = sh_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = WIDTH'(in_a);
          sh_d    = in_w;
          last_d  = in_last || (cnt_q == CNT_W'(ROW_LEN - 1));
          state_d = (in_w != '0) ? SHIFT : ACCUM;
        end
      end
      SHIFT: begin
        x_d  = dbl_sum;
        sh_d = sh_q - SHIFT_W'(1);
        if (sh_q == SHIFT_W'(1)) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        sum_d   = acc_sum;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Element working registers are only meaningful after an accept.
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    sh_q   <= sh_d;
    last_q <= last_d;
  end

endmodule

// File: tb/tb_mod_row_accum.sv
// Bench for mod_row_accum at WIDTH=8, A_W=6, MODULUS=97, ROW_LEN=4.
module tb_mod_row_accum;
  localparam int MOD  = 97;
  localparam int RLEN = 4;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [5:0] in_a = '0;
  logic [7:0] in_w = '0;
  logic       in_last = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] out_data;
  logic [2:0] out_count;

  mod_row_accum #(.WIDTH(8), .A_W(6), .SHIFT_W(8), .ROW_LEN(RLEN), .MODULUS(8'd97)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_w(in_w), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_d[$];
  int exp_c[$];
  int row_acc = 0;
  int row_n = 0;
  int n_out = 0;
  int last_d = 0;
  int last_c = 0;
  int first_acc_edge = 0;
  int rise_edge = 0;
  bit prev_ov = 0;
  bit rnd_bp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: row sum of a*2^w mod 97, rows closed by in_last or the 4th element.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_d.delete();
      exp_c.delete();
      row_acc = 0;
      row_n   = 0;
      prev_ov = 0;
    end else begin
      if (in_valid && in_ready) begin
        if (row_n == 0) first_acc_edge = cyc + 1;
        row_acc = int'((longint'(row_acc) + ((longint'(in_a) << in_w) % MOD)) % MOD);
        row_n++;
        if (in_last || row_n == RLEN) begin
          exp_d.push_back(row_acc);
          exp_c.push_back(row_n);
          row_acc = 0;
          row_n   = 0;
        end
      end
      if (out_valid) begin
        if (!prev_ov) rise_edge = cyc;
        chk("in_ready_during_out", 32'(in_ready), 0);
        if (exp_d.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_d[0]));
          chk("out_count", 32'(out_count), 32'(exp_c[0]));
          if (out_ready) begin
            last_d = int'(out_data);
            last_c = int'(out_count);
            n_out++;
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int a, input int w, input bit last);
    bit ok;
    in_a     = 6'(a);
    in_w     = 8'(w);
    in_last  = last;
    in_valid = 1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n_before);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (n_out > n_before) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  task automatic expect_row(input string nm, input int d, input int c);
    chk({nm, "_data"}, 32'(last_d), 32'(d));
    chk({nm, "_count"}, 32'(last_c), 32'(c));
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit ok;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    @(posedge clk);
    #1 rst_n = 1;

    // Basic row, in_valid held
    n0 = n_out;
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    in_valid = 0;
    wait_out(n0);
    expect_row("basic", 10, 4);
    chk("basic_latency", 32'(rise_edge - first_acc_edge), 7);

    // Shift wrap: 1*2^10 mod 97
    @(posedge clk); #1;
    n0 = n_out;
    send(1, 10, 1);
    in_valid = 0;
    wait_out(n0);
    expect_row("shiftwrap", 54, 1);
    chk("shiftwrap_latency", 32'(rise_edge - first_acc_edge), 11);

    // Accumulate wrap
    @(posedge clk); #1;
    n0 = n_out;
    send(60, 1, 0); send(60, 0, 1);
    in_valid = 0;
    wait_out(n0);
    expect_row("accwrap2", 83, 2);
    @(posedge clk); #1;
    n0 = n_out;
    send(60, 0, 0); send(60, 0, 0); send(60, 0, 0); send(0, 0, 0);
    in_valid = 0;
    wait_out(n0);
    expect_row("accwrap4", 83, 4);

    // Backpressure with next element pending
    @(posedge clk); #1;
    out_ready = 0;
    n0 = n_out;
    send(3, 2, 1);
    in_a = 6'd2; in_w = 8'd0; in_last = 1; in_valid = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("bp_out_seen", 32'(ok), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_data_stable", 32'(out_data), 12);
      chk("bp_count_stable", 32'(out_count), 1);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_handoff_in_ready", 32'(in_ready), 1);
    chk("bp_handoff_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1 in_valid = 0;
    wait_out(n0 + 1);
    expect_row("bp_next", 2, 1);

    // Reset during SHIFT discards the partial row
    @(posedge clk); #1;
    send(5, 0, 0);
    send(7, 5, 0);
    @(posedge clk); #1 in_valid = 0;
    #2 rst_n = 0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_count", 32'(out_count), 0);
    @(posedge clk); #1 rst_n = 1;
    n0 = n_out;
    send(1, 0, 1);
    in_valid = 0;
    wait_out(n0);
    expect_row("after_rst", 1, 1);

    // Random elements with random consumer stalls
    @(posedge clk); #1;
    rnd_bp = 1;
    for (int k = 0; k < 40; k++) begin
      in_valid = 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
    send(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), 1);
    in_valid = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_d.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("random_drain", 32'(ok), 1);
    rnd_bp = 0;
    @(posedge clk); #2 out_ready = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
